digit_serial_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor. Processes DIGIT bits per clock,

---
 rtl/digit_serial_adder.sv | 96 +++++++++
 tb/tb_digit_serial_adder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSD first,
// through a registered carry. start/busy/done handshake, signed overflow flag.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4    // must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, shadow, shadow_nxt;
    logic             carry, last, c_msb;
    logic [DIGIT:0]   slice;

    assign last  = (cnt == CW'(NDIG - 1));
    assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry);
    // Result digits enter at the top so the shadow is aligned after the last slice.
    assign shadow_nxt = (shadow >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
    assign c_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // Subtract as a + ~b + ~cin so one adder serves both modes.
                    a_q   <= a;
                    b_q   <= sub ? ~b : b;
                    carry <= sub ? ~cin : cin;
                    cnt   <= '0;
                end
                RUN: begin
                    a_q    <= a_q >> DIGIT;
                    b_q    <= b_q >> DIGIT;
                    carry  <= slice[DIGIT];
                    shadow <= shadow_nxt;
                    if (last) begin
                        cnt  <= '0;
                        done <= 1'b1;
                        sum  <= shadow_nxt;
                        co   <= slice[DIGIT];
                        ovf  <= c_msb ^ slice[DIGIT];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomized + directed bench for digit_serial_adder against an arithmetic
// reference model; exhaustive WIDTH=4 sweep at DIGIT=1, 2 and 4.
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance, 16/4
    logic        start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, co, ovf;
    logic [15:0] sum;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .co(co), .ovf(ovf));

    // three 4-bit instances sharing stimulus
    logic       s_start = 1'b0, s_cin = 1'b0, s_sub = 1'b0;
    logic [3:0] s_a = '0, s_b = '0;
    logic [2:0] s_busy, s_done, s_co, s_ovf;
    logic [2:0][3:0] s_sum;

    digit_serial_adder #(.WIDTH(4), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .busy(s_busy[0]), .done(s_done[0]), .sum(s_sum[0]), .co(s_co[0]), .ovf(s_ovf[0]));
    digit_serial_adder #(.WIDTH(4), .DIGIT(2)) dut_d2 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .busy(s_busy[1]), .done(s_done[1]), .sum(s_sum[1]), .co(s_co[1]), .ovf(s_ovf[1]));
    digit_serial_adder #(.WIDTH(4), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .busy(s_busy[2]), .done(s_done[2]), .sum(s_sum[2]), .co(s_co[2]), .ovf(s_ovf[2]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {co, ovf, sum[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] ref_model(int w, int ua, int ub, bit c, bit s);
        int mask, half, r, sa, sb, sr;
        logic [17:0] res;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        r    = s ? ua - ub - int'(c) : ua + ub + int'(c);
        sa   = (ua >= half) ? ua - (1 << w) : ua;
        sb   = (ub >= half) ? ub - (1 << w) : ub;
        sr   = s ? sa - sb - int'(c) : sa + sb + int'(c);
        res        = '0;
        res[15:0]  = 16'(r & mask);
        res[17]    = s ? (r >= 0) : (r > mask);
        res[16]    = (sr > half - 1) || (sr < -half);
        return res;
    endfunction

    function automatic logic [17:0] got16();
        return {co, ovf, sum};
    endfunction

    // Start an op, scramble inputs while it runs, check latency, busy and result.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input bit tc, input bit ts);
        int lat;
        bit busy_ok;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_busy_run"}, 32'(busy_ok), 1);
        chk({tag, "_busy_done"}, 32'(busy), 0);
        chk({tag, "_result"}, 32'(got16()), 32'(ref_model(16, ta, tb_, tc, ts)));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        int lat, ndone, gap;
        logic [17:0] exp;
        logic [2:0][3:0] dcnt;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {26'd0, busy, done, co, ovf, sum != 0, s_busy != 0},
            32'd0);

        // directed corner cases
        run_op("ffff_p1", 16'hFFFF, 16'h0001, 0, 0);
        chk("ffff_p1_abs", 32'(got16()), {14'd0, 2'b10, 16'h0000});
        run_op("pos_ovf", 16'h7FFF, 16'h0001, 0, 0);
        chk("pos_ovf_abs", 32'(got16()), {14'd0, 2'b01, 16'h8000});
        run_op("neg_ovf", 16'h8000, 16'h8000, 0, 0);
        chk("neg_ovf_abs", 32'(got16()), {14'd0, 2'b11, 16'h0000});
        run_op("sub_neg", 16'h0005, 16'h0007, 0, 1);
        chk("sub_neg_abs", 32'(got16()), {14'd0, 2'b00, 16'hFFFE});
        run_op("sub_ovf", 16'h8000, 16'h0001, 0, 1);
        chk("sub_ovf_abs", 32'(got16()), {14'd0, 2'b11, 16'h7FFF});
        run_op("sub_bin", 16'h0000, 16'h0000, 1, 1);
        run_op("add_cin", 16'h1234, 16'h0FFF, 1, 0);

        // random
        for (int i = 0; i < 40; i++)
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

        // start while busy is ignored
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; cin = 1; sub = 1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("busy_start_dones", ndone, 1);
        chk("busy_start_result", 32'(got16()), 32'(ref_model(16, 16'h1111, 16'h2222, 0, 0)));
        chk("busy_start_idle", 32'(busy), 0);

        // start held through done: back-to-back, done gap 5
        a = 16'h00FF; b = 16'h0F0F; cin = 0; sub = 0; start = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        chk("b2b_first", 32'(got16()), 32'(ref_model(16, 16'h00FF, 16'h0F0F, 0, 0)));
        a = 16'h8001; b = 16'h7FFF; cin = 1; sub = 1;
        gap = 0;
        @(negedge clk); gap++;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        start = 1'b0;
        chk("b2b_gap", gap, 5);
        chk("b2b_second", 32'(got16()), 32'(ref_model(16, 16'h8001, 16'h7FFF, 1, 1)));
        @(negedge clk);
        @(negedge clk);
        chk("b2b_no_third", 32'(busy), 0);

        // reset mid-run: ensure nonzero result first
        run_op("pre_rst", 16'hFFFF, 16'hFFFF, 0, 0);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 0; sub = 0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outs", {27'd0, busy, done, co, ovf, sum != 0}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", ndone, 0);
        run_op("post_rst", 16'hBEEF, 16'h1234, 1, 1);

        // exhaustive 4-bit at DIGIT=1,2,4
        for (int ia = 0; ia < 16; ia++)
          for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
              for (int is = 0; is < 2; is++) begin
                @(negedge clk);
                s_a = 4'(ia); s_b = 4'(ib); s_cin = 1'(ic); s_sub = 1'(is); s_start = 1'b1;
                @(negedge clk);
                s_start = 1'b0;
                dcnt = '0;
                for (int t = 0; t < 6; t++) begin
                    for (int d = 0; d < 3; d++) if (s_done[d]) dcnt[d] = dcnt[d] + 4'd1;
                    s_a = 4'($urandom); s_b = 4'($urandom);
                    @(negedge clk);
                end
                exp = ref_model(4, ia, ib, 1'(ic), 1'(is));
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("exh_d%0d_%h_%h_%0d_%0d", d, ia, ib, ic, is),
                        {dcnt[d], 9'd0, s_co[d], s_ovf[d], 12'd0, s_sum[d]},
                        {4'd1, 9'd0, exp[17], exp[16], 12'd0, exp[3:0]});
                end
              end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
